// File: rtl/axis_ptp_tx_arbiter.sv
// Packet-granular 2:1 AXIS arbiter for the MAC TX path.
// Port 0 carries PTP traffic and wins at frame boundaries, up to a burst limit
// while best-effort traffic on port 1 waits. An idle gap follows every frame.
// tx_is_ptp and tx_sof feed the TX timestamp unit.
module axis_ptp_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int MAX_PTP_BURST = 4,
  parameter int CNT_W         = 32
) (
  input  logic             axis_aclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             s0_axis_tvalid,
  output logic             s0_axis_tready,
  input  logic [7:0]       s0_axis_tdata,
  input  logic             s0_axis_tlast,
  input  logic             s1_axis_tvalid,
  output logic             s1_axis_tready,
  input  logic [7:0]       s1_axis_tdata,
  input  logic             s1_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             tx_is_ptp,
  output logic             tx_sof,
  output logic [CNT_W-1:0] ptp_frame_cnt,
  output logic [CNT_W-1:0] be_frame_cnt
);

  localparam int RUN_W = $clog2(MAX_PTP_BURST + 1);
  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_PTP_BURST);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             grant, grant_nxt;
  logic [RUN_W-1:0] ptp_run, ptp_run_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic             first_beat;
  logic             m_hs;

  // Arbitration state register: grant and burst/gap counters move with the FSM
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= 1'b0;
      ptp_run <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      ptp_run <= ptp_run_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Next-state logic plus the datapath mux that routes the granted port to the MAC
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    ptp_run_nxt    = ptp_run;
    gap_cnt_nxt    = gap_cnt;
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = 8'h00;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    m_hs           = 1'b0;
    case (state)
      IDLE: begin
        if (enable && s0_axis_tvalid && ((ptp_run < RUN_MAX) || !s1_axis_tvalid)) begin
          state_nxt = PASS;
          grant_nxt = 1'b0;
          if (ptp_run < RUN_MAX) ptp_run_nxt = ptp_run + RUN_W'(1);
        end else if (enable && s1_axis_tvalid) begin
          state_nxt   = PASS;
          grant_nxt   = 1'b1;
          ptp_run_nxt = '0;
        end else if (!s0_axis_tvalid && !s1_axis_tvalid) begin
          ptp_run_nxt = '0;
        end
      end
      PASS: begin
        if (grant) begin
          m_axis_tvalid  = s1_axis_tvalid;
          m_axis_tdata   = s1_axis_tdata;
          m_axis_tlast   = s1_axis_tlast;
          s1_axis_tready = m_axis_tready;
        end else begin
          m_axis_tvalid  = s0_axis_tvalid;
          m_axis_tdata   = s0_axis_tdata;
          m_axis_tlast   = s0_axis_tlast;
          s0_axis_tready = m_axis_tready;
        end
        m_hs = m_axis_tvalid && m_axis_tready;
        if (m_hs && m_axis_tlast) begin
          gap_cnt_nxt = '0;
          if (IFG_CYCLES > 0) state_nxt = GAP;
          else                state_nxt = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_cnt_nxt = gap_cnt + GAP_W'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  // PTP flag follows the registered grant so it is stable for the whole frame
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) tx_is_ptp <= 1'b0;
    else        tx_is_ptp <= (state_nxt == PASS) && !grant_nxt;
  end

  // Start-of-frame pulse lands one cycle after the first beat actually transfers
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      first_beat <= 1'b0;
      tx_sof     <= 1'b0;
    end else begin
      tx_sof <= m_hs && first_beat;
      if (state == IDLE && state_nxt == PASS) first_beat <= 1'b1;
      else if (m_hs)                          first_beat <= 1'b0;
    end
  end

  // Per-port frame counters bump on the owning port's tlast handshake and wrap
  always_ff @(posedge axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      ptp_frame_cnt <= '0;
      be_frame_cnt  <= '0;
    end else if (m_hs && m_axis_tlast) begin
      if (grant) be_frame_cnt  <= be_frame_cnt + CNT_W'(1);
      else       ptp_frame_cnt <= ptp_frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_ptp_tx_arbiter.sv
// Bench for axis_ptp_tx_arbiter: queue-fed sources, a frame-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_axis_ptp_tx_arbiter;

  localparam int IFG  = 12;
  localparam int MAXB = 4;
  localparam int CW   = 32;

  logic          axis_aclk;
  logic          rst_n;
  logic          enable;
  logic          s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic [7:0]    s0_axis_tdata;
  logic          s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic [7:0]    s1_axis_tdata;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [7:0]    m_axis_tdata;
  logic          tx_is_ptp, tx_sof;
  logic [CW-1:0] ptp_frame_cnt, be_frame_cnt;

  axis_ptp_tx_arbiter #(
    .IFG_CYCLES   (IFG),
    .MAX_PTP_BURST(MAXB),
    .CNT_W        (CW)
  ) dut (
    .axis_aclk     (axis_aclk),
    .rst_n         (rst_n),
    .enable        (enable),
    .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tready(s0_axis_tready),
    .s0_axis_tdata (s0_axis_tdata),
    .s0_axis_tlast (s0_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tready(s1_axis_tready),
    .s1_axis_tdata (s1_axis_tdata),
    .s1_axis_tlast (s1_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .tx_is_ptp     (tx_is_ptp),
    .tx_sof        (tx_sof),
    .ptp_frame_cnt (ptp_frame_cnt),
    .be_frame_cnt  (be_frame_cnt)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  int n_checks;
  int n_pass;
  int cyc;
  int m_bytes;
  int sof_count;
  int ptp_beats;
  bit rdy_random;
  logic [8:0] src_q0[$], src_q1[$], exp_q0[$], exp_q1[$];
  int obs_order[$];
  int tlast_cyc[$];
  int rise_cyc[$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Queue one frame of len bytes (base, base+1, ...) on the given port
  task automatic applyStimulus(input int port, input int len, input logic [7:0] base);
    for (int i = 0; i < len; i++) begin
      logic [8:0] w;
      w = {(i == len - 1), 8'(int'(base) + i)};
      if (port == 0) begin src_q0.push_back(w); exp_q0.push_back(w); end
      else           begin src_q1.push_back(w); exp_q1.push_back(w); end
    end
  endtask

  task automatic tick();
    @(posedge axis_aclk);
    #2;
  endtask

  task automatic wait_frames(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (obs_order.size() < n && k < budget) begin tick(); k++; end
    checkOutput(name, 64'(obs_order.size() >= n), 64'd1);
  endtask

  task automatic wait_bytes(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (m_bytes < n && k < budget) begin tick(); k++; end
    checkOutput(name, 64'(m_bytes >= n), 64'd1);
  endtask

  function automatic logic [63:0] order_bits();
    logic [63:0] b;
    b = '0;
    foreach (obs_order[i]) b = {b[62:0], obs_order[i][0]};
    return b;
  endfunction

  // Sources present queue heads; sink tready is either steady or random
  initial begin : source_driver
    bit hs0, hs1;
    s0_axis_tvalid = 1'b0; s0_axis_tdata = 8'h00; s0_axis_tlast = 1'b0;
    s1_axis_tvalid = 1'b0; s1_axis_tdata = 8'h00; s1_axis_tlast = 1'b0;
    m_axis_tready  = 1'b1;
    forever begin
      @(negedge axis_aclk);
      hs0 = s0_axis_tvalid && s0_axis_tready;
      hs1 = s1_axis_tvalid && s1_axis_tready;
      @(posedge axis_aclk);
      #1;
      if (hs0 && src_q0.size() > 0) void'(src_q0.pop_front());
      if (hs1 && src_q1.size() > 0) void'(src_q1.pop_front());
      s0_axis_tvalid = (src_q0.size() > 0);
      s0_axis_tdata  = (src_q0.size() > 0) ? src_q0[0][7:0] : 8'h00;
      s0_axis_tlast  = (src_q0.size() > 0) ? src_q0[0][8]   : 1'b0;
      s1_axis_tvalid = (src_q1.size() > 0);
      s1_axis_tdata  = (src_q1.size() > 0) ? src_q1[0][7:0] : 8'h00;
      s1_axis_tlast  = (src_q1.size() > 0) ? src_q1[0][8]   : 1'b0;
      m_axis_tready  = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Frame-level reference model: who owns the link, when arbitration may
  // happen again, and what each output must be, compared every cycle
  initial begin : model_compare
    bit in_frame, first, sof_exp, prev_mv, v0, v1;
    int port, run, idle_from;
    logic [CW-1:0] c0, c1;
    logic [9:0] e;
    in_frame = 0; first = 0; sof_exp = 0; prev_mv = 0;
    port = 0; run = 0; idle_from = 0; c0 = '0; c1 = '0;
    forever begin
      @(negedge axis_aclk);
      cyc++;
      if (!rst_n) begin
        checkOutput("reset_outputs",
                    {m_axis_tvalid, m_axis_tlast, m_axis_tdata, s0_axis_tready,
                     s1_axis_tready, tx_is_ptp, tx_sof}, 64'd0);
        checkOutput("reset_counters", {ptp_frame_cnt, be_frame_cnt}, 64'd0);
        in_frame = 0; first = 0; sof_exp = 0; prev_mv = 0;
        run = 0; c0 = '0; c1 = '0; idle_from = cyc + 1;
      end else begin
        checkOutput("tx_sof", tx_sof, sof_exp);
        if (tx_sof) sof_count++;
        checkOutput("ptp_frame_cnt", ptp_frame_cnt, c0);
        checkOutput("be_frame_cnt", be_frame_cnt, c1);
        if (in_frame) begin
          checkOutput("m_tvalid_in_frame", m_axis_tvalid, (port == 0) ? s0_axis_tvalid : s1_axis_tvalid);
          checkOutput("tready_granted", (port == 0) ? s0_axis_tready : s1_axis_tready, m_axis_tready);
          checkOutput("tready_other", (port == 0) ? s1_axis_tready : s0_axis_tready, 64'd0);
          checkOutput("tx_is_ptp", tx_is_ptp, 64'(port == 0));
        end else begin
          checkOutput("outputs_between_frames",
                      {m_axis_tvalid, s0_axis_tready, s1_axis_tready, tx_is_ptp}, 64'd0);
        end
        if (m_axis_tvalid && !prev_mv) rise_cyc.push_back(cyc);
        prev_mv = m_axis_tvalid;
        sof_exp = 0;
        if (in_frame && m_axis_tvalid && m_axis_tready) begin
          if (port == 0) e = (exp_q0.size() > 0) ? {1'b0, exp_q0.pop_front()} : 10'h200;
          else           e = (exp_q1.size() > 0) ? {1'b0, exp_q1.pop_front()} : 10'h200;
          checkOutput("m_beat_last_data", {1'b0, m_axis_tlast, m_axis_tdata}, e);
          m_bytes++;
          if (tx_is_ptp) ptp_beats++;
          if (first) sof_exp = 1;
          first = 0;
          if (m_axis_tlast) begin
            in_frame = 0;
            obs_order.push_back(port);
            tlast_cyc.push_back(cyc);
            if (port == 0) c0++;
            else           c1++;
            idle_from = cyc + IFG + 1;
          end
        end else if (!in_frame && cyc >= idle_from) begin
          v0 = s0_axis_tvalid;
          v1 = s1_axis_tvalid;
          if (enable && v0 && (run < MAXB || !v1)) begin
            in_frame = 1; port = 0; first = 1;
            if (run < MAXB) run++;
          end else if (enable && v1) begin
            in_frame = 1; port = 1; first = 1; run = 0;
          end else if (!v0 && !v1) begin
            run = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int b0, s0c, pb0;
    n_checks = 0; n_pass = 0; cyc = 0; m_bytes = 0; sof_count = 0; ptp_beats = 0;
    rdy_random = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    enable = 1'b1;
    tick();

    $display("[TB] 1: best-effort only, 60-byte frame");
    b0 = m_bytes;
    applyStimulus(1, 60, 8'h10);
    wait_frames(1, 300, "t1_done");
    repeat (3) tick();
    checkOutput("t1_bytes", 64'(m_bytes - b0), 64'd60);
    checkOutput("t1_be_cnt", be_frame_cnt, 64'd1);
    checkOutput("t1_ptp_cnt", ptp_frame_cnt, 64'd0);
    repeat (20) tick();

    $display("[TB] 2: simultaneous requests, PTP first");
    obs_order.delete(); tlast_cyc.delete(); rise_cyc.delete();
    s0c = sof_count; pb0 = ptp_beats;
    applyStimulus(0, 8, 8'h80);
    applyStimulus(1, 8, 8'hC0);
    wait_frames(2, 300, "t2_done");
    repeat (3) tick();
    checkOutput("t2_count", 64'(obs_order.size()), 64'd2);
    checkOutput("t2_order", order_bits(), 64'b01);
    checkOutput("t2_sof_pulses", 64'(sof_count - s0c), 64'd2);
    checkOutput("t2_ptp_beats", 64'(ptp_beats - pb0), 64'd8);
    checkOutput("t2_gap_to_next_valid", 64'(rise_cyc[1] - tlast_cyc[0]), 64'(IFG + 2));
    checkOutput("t2_ptp_cnt", ptp_frame_cnt, 64'd1);
    checkOutput("t2_be_cnt", be_frame_cnt, 64'd2);
    repeat (20) tick();

    $display("[TB] 3: PTP burst limit with best-effort pending");
    obs_order.delete();
    for (int f = 0; f < 10; f++) applyStimulus(0, 4, 8'(8'h00 + f * 16));
    for (int f = 0; f < 3; f++)  applyStimulus(1, 4, 8'(8'hA0 + f * 4));
    wait_frames(13, 800, "t3_done");
    repeat (3) tick();
    checkOutput("t3_count", 64'(obs_order.size()), 64'd13);
    checkOutput("t3_order", order_bits(), 64'b0000100001001);
    checkOutput("t3_ptp_cnt", ptp_frame_cnt, 64'd11);
    checkOutput("t3_be_cnt", be_frame_cnt, 64'd5);
    repeat (20) tick();

    $display("[TB] 4: random sink backpressure during 64-byte frame");
    obs_order.delete();
    b0 = m_bytes;
    rdy_random = 1;
    applyStimulus(0, 64, 8'h00);
    applyStimulus(1, 8, 8'hA0);
    wait_frames(2, 1000, "t4_done");
    rdy_random = 0;
    repeat (3) tick();
    checkOutput("t4_order", order_bits(), 64'b01);
    checkOutput("t4_bytes", 64'(m_bytes - b0), 64'd72);
    checkOutput("t4_ptp_cnt", ptp_frame_cnt, 64'd12);
    checkOutput("t4_be_cnt", be_frame_cnt, 64'd6);
    repeat (20) tick();

    $display("[TB] 5: enable dropped mid-frame");
    obs_order.delete();
    b0 = m_bytes;
    applyStimulus(1, 30, 8'h40);
    wait_bytes(b0 + 10, 200, "t5_ten_bytes");
    enable = 1'b0;
    applyStimulus(0, 6, 8'h60);
    wait_frames(1, 200, "t5_frame_completes");
    repeat (30) tick();
    checkOutput("t5_held_frames", 64'(obs_order.size()), 64'd1);
    checkOutput("t5_held_tvalid", m_axis_tvalid, 64'd0);
    checkOutput("t5_be_cnt", be_frame_cnt, 64'd7);
    checkOutput("t5_ptp_cnt_held", ptp_frame_cnt, 64'd12);
    enable = 1'b1;
    wait_frames(2, 200, "t5_resume");
    repeat (3) tick();
    checkOutput("t5_order", order_bits(), 64'b10);
    checkOutput("t5_ptp_cnt", ptp_frame_cnt, 64'd13);
    repeat (20) tick();

    $display("[TB] 6: reset mid-frame");
    obs_order.delete();
    b0 = m_bytes;
    applyStimulus(1, 40, 8'h20);
    wait_bytes(b0 + 20, 200, "t6_twenty_bytes");
    rst_n = 1'b0;
    src_q0.delete(); src_q1.delete(); exp_q0.delete(); exp_q1.delete();
    #1;
    checkOutput("t6_async_m_tvalid", m_axis_tvalid, 64'd0);
    checkOutput("t6_async_treadys", {s0_axis_tready, s1_axis_tready}, 64'd0);
    checkOutput("t6_async_flags", {tx_is_ptp, tx_sof}, 64'd0);
    checkOutput("t6_async_counters", {ptp_frame_cnt, be_frame_cnt}, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(1, 16, 8'h90);
    wait_frames(1, 200, "t6_fresh_frame");
    repeat (3) tick();
    checkOutput("t6_order", order_bits(), 64'b1);
    checkOutput("t6_be_cnt", be_frame_cnt, 64'd1);
    checkOutput("t6_ptp_cnt", ptp_frame_cnt, 64'd0);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
